// File: rtl/uart_pkg.sv
// Shared UART definitions: TX arbiter state encoding and default line timing
// constants used by the transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int CLK_HZ     = 50_000_000;
  localparam int BAUD       = 115_200;
  localparam int OVERSAMPLE = 16;
  localparam int FRAME_BITS = 10;
  localparam int BAUD_DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int OS_DIV     = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);

endpackage

// File: rtl/rr_pick.sv
// Rotating priority search: first set bit of req starting at ptr, wrapping modulo NREQ.
// Purely combinational; NREQ must be a power of two so the index wraps naturally.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  winner
);

  // Scan from the farthest position back to ptr so the closest hit wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[ptr + IDW'(k)]) begin
        found  = 1'b1;
        winner = ptr + IDW'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART transmitter among NREQ byte sources,
// sequencing each byte through start pulse, busy-wait (with start timeout) and completion.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int START_TO = 15,
  parameter int TOW      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ack,
  output logic              st_tx,
  output logic [7:0]        DataOUT,
  input  logic              rdy_Tx,
  output logic              busy,
  output logic [IDW-1:0]    owner,
  output logic              tx_err
);

  arb_state_t     state;
  logic [IDW-1:0] ptr;
  logic           lock;
  logic           last_q;
  logic [TOW-1:0] cnt;

  logic [NREQ-1:0] elig;
  logic [IDW-1:0]  pick_ptr;
  logic [IDW-1:0]  winner;
  logic            found;
  logic [7:0]      req_byte [NREQ];
  logic            timeout;
  logic            byte_end;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_byte[i] = req_data[8*i +: 8];
    end
  end

  // While a packet is open only its owner may be picked, even if it is momentarily idle.
  always_comb begin
    elig     = req_valid;
    pick_ptr = ptr;
    if (lock) begin
      elig     = req_valid & (NREQ'(1) << owner);
      pick_ptr = owner;
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (elig),
    .ptr    (pick_ptr),
    .found  (found),
    .winner (winner)
  );

  assign timeout  = (state == WAIT_BUSY) && rdy_Tx && (cnt == TOW'(START_TO - 1));
  assign byte_end = timeout || ((state == WAIT_DONE) && rdy_Tx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      st_tx   <= 1'b0;
      req_ack <= '0;
      tx_err  <= 1'b0;
      busy    <= 1'b0;
      DataOUT <= '0;
      owner   <= '0;
      ptr     <= '0;
      lock    <= 1'b0;
      last_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      st_tx   <= 1'b0;
      req_ack <= '0;
      tx_err  <= timeout;
      case (state)
        IDLE: begin
          if (rdy_Tx && found) begin
            DataOUT <= req_byte[winner];
            owner   <= winner;
            last_q  <= req_last[winner];
            req_ack <= NREQ'(1) << winner;
            st_tx   <= 1'b1;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!rdy_Tx) begin
            state <= WAIT_DONE;
          end else if (!timeout) begin
            cnt <= cnt + TOW'(1);
          end
        end
        WAIT_DONE: begin
        end
        default: state <= IDLE;
      endcase
      // A timed-out byte was already acked, so it closes the packet state like a normal one.
      if (byte_end) begin
        state <= IDLE;
        busy  <= 1'b0;
        if (last_q) begin
          lock <= 1'b0;
          ptr  <= owner + IDW'(1);
        end else begin
          lock <= 1'b1;
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) $onehot0(req_ack));
  assert property (@(posedge clk) disable iff (rst) st_tx == (req_ack != '0));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: per-requester byte queues, a simple UART busy model,
// and a grant scoreboard derived from the round-robin / packet-lock rules.
module tb_uart_tx_arbiter;

  localparam int NREQ      = 4;
  localparam int IDW       = 2;
  localparam int START_TO  = 15;
  localparam int TOW       = 4;
  localparam int UM_AUTO   = 0;
  localparam int UM_STUCK  = 1;
  localparam int UM_MANUAL = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   req_ack;
  logic              st_tx;
  logic [7:0]        DataOUT;
  logic              rdy_Tx = 1'b1;
  logic              busy;
  logic [IDW-1:0]    owner;
  logic              tx_err;

  uart_tx_arbiter #(
    .NREQ     (NREQ),
    .IDW      (IDW),
    .START_TO (START_TO),
    .TOW      (TOW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ack   (req_ack),
    .st_tx     (st_tx),
    .DataOUT   (DataOUT),
    .rdy_Tx    (rdy_Tx),
    .busy      (busy),
    .owner     (owner),
    .tx_err    (tx_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int uart_mode = UM_AUTO;
  int busy_left = 0;

  logic [8:0] src_mem [NREQ][16];
  int         src_len [NREQ];
  int         src_head[NREQ];
  bit         hold    [NREQ];
  logic [NREQ-1:0] adv_pend = '0;

  int         m_ptr, m_lock, m_owner, g_idx;
  logic [7:0] g_data;
  logic       g_last;
  bit         g_valid, prev_busy;
  int         glog[$];

  function automatic int model_pick(input logic [NREQ-1:0] v);
    if (m_lock != 0) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (src_head[i] < src_len[i] && !hold[i]) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = src_mem[i][src_head[i]][7:0];
        req_last[i]       = src_mem[i][src_head[i]][8];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic push_byte(input int i, input logic [7:0] d, input logic last);
    src_mem[i][src_len[i]] = {last, d};
    src_len[i]++;
  endtask

  // One clock: scoreboard the outputs against inputs seen at this edge, then requesters and UART react.
  task automatic step();
    int w;
    int a;
    logic [NREQ-1:0] exp_ack;
    @(posedge clk);
    #1;
    cyc++;
    if (st_tx || req_ack != '0) begin
      w = model_pick(req_valid);
      exp_ack = (w >= 0) ? (NREQ'(1) << w) : '0;
      n_tests++;
      if (w < 0 || req_ack !== exp_ack || st_tx !== 1'b1 || rdy_Tx !== 1'b1 ||
          owner !== IDW'(w) || DataOUT !== req_data[8*w +: 8]) begin
        n_fail++;
        $display("FAIL grant @%0d: ack=%b st_tx=%b owner=%0d data=%h rdy=%b, expected requester %0d",
                 cyc, req_ack, st_tx, owner, DataOUT, rdy_Tx, w);
      end
      a = -1;
      for (int i = NREQ - 1; i >= 0; i--) if (req_ack[i]) a = i;
      glog.push_back(a);
      if (w >= 0) begin
        g_idx = w; g_data = req_data[8*w +: 8]; g_last = req_last[w]; g_valid = 1'b1; m_owner = w;
      end
    end else if (busy && g_valid) begin
      n_tests++;
      if (DataOUT !== g_data) begin
        n_fail++;
        $display("FAIL data_hold @%0d: DataOUT=%h, expected %h", cyc, DataOUT, g_data);
      end
    end
    if (prev_busy && !busy) begin
      n_tests++;
      if (!tx_err && rdy_Tx !== 1'b1) begin
        n_fail++;
        $display("FAIL byte_end @%0d: busy fell with rdy_Tx=%b, expected 1", cyc, rdy_Tx);
      end
      if (g_last) begin
        m_lock = 0;
        m_ptr  = (g_idx + 1) % NREQ;
      end else begin
        m_lock = 1;
      end
    end
    if (tx_err) begin
      n_tests++;
      if (uart_mode != UM_STUCK) begin
        n_fail++;
        $display("FAIL spurious_tx_err @%0d: tx_err=%b, expected 0", cyc, tx_err);
      end
    end
    prev_busy = busy;
    for (int i = 0; i < NREQ; i++) if (adv_pend[i]) src_head[i]++;
    adv_pend = req_ack;
    drive_reqs();
    if (uart_mode == UM_AUTO) begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) rdy_Tx = 1'b1;
      end else if (st_tx) begin
        rdy_Tx    = 1'b0;
        busy_left = $urandom_range(2, 8);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      src_len[i] = 0; src_head[i] = 0; hold[i] = 1'b0;
    end
    adv_pend = '0;
    drive_reqs();
    rdy_Tx = 1'b1; uart_mode = UM_AUTO; busy_left = 0;
    m_ptr = 0; m_lock = 0; m_owner = 0; g_valid = 1'b0; g_last = 1'b0; prev_busy = 1'b0;
    glog.delete();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic wait_acks(input int n, input int limit, input string name);
    int t = 0;
    while (glog.size() < n && t < limit) begin
      step();
      t++;
    end
    n_tests++;
    if (glog.size() < n) begin
      n_fail++;
      $display("FAIL %s: %0d acks seen, expected %0d", name, glog.size(), n);
    end
  endtask

  task automatic wait_idle(input int limit, input string name);
    int t = 0;
    while (busy && t < limit) begin
      step();
      t++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: busy=%b, expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (busy    !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_tests++; if (st_tx   !== 1'b0) begin n_fail++; $display("FAIL reset_st_tx: got %b, expected 0", st_tx); end
    n_tests++; if (req_ack !== '0)   begin n_fail++; $display("FAIL reset_ack: got %b, expected 0", req_ack); end
    n_tests++; if (tx_err  !== 1'b0) begin n_fail++; $display("FAIL reset_tx_err: got %b, expected 0", tx_err); end
    n_tests++; if (DataOUT !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, expected 00", DataOUT); end
    n_tests++; if (owner   !== '0)   begin n_fail++; $display("FAIL reset_owner: got %0d, expected 0", owner); end
  endtask

  task automatic test_single();
    do_reset();
    uart_mode = UM_MANUAL;
    push_byte(0, 8'h55, 1'b1);
    drive_reqs();
    wait_acks(1, 10, "single_ack_wait");
    n_tests++;
    if (req_ack !== 4'b0001 || st_tx !== 1'b1 || DataOUT !== 8'h55) begin
      n_fail++;
      $display("FAIL single_grant: ack=%b st_tx=%b data=%h, expected 0001 1 55", req_ack, st_tx, DataOUT);
    end
    rdy_Tx = 1'b0;
    repeat (100) step();
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_held: busy=%b, expected 1", busy); end
    rdy_Tx = 1'b1;
    step();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_release: busy=%b, expected 0", busy); end
    uart_mode = UM_AUTO;
    push_byte(0, 8'($urandom), 1'b1);
    push_byte(1, 8'($urandom), 1'b1);
    drive_reqs();
    wait_acks(2, 20, "single_next_wait");
    n_tests++;
    if (glog.size() < 2 || glog[1] != 1) begin
      n_fail++;
      $display("FAIL single_ptr: winner=%0d, expected 1", (glog.size() < 2) ? -1 : glog[1]);
    end
    wait_acks(3, 40, "single_drain");
    wait_idle(40, "single_idle");
  endtask

  task automatic test_fairness();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NREQ; i++) push_byte(i, 8'($urandom), 1'b1);
    end
    drive_reqs();
    wait_acks(8, 400, "fair_wait");
    wait_idle(40, "fair_idle");
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (k >= glog.size() || glog[k] != k % NREQ) begin
        n_fail++;
        $display("FAIL fair_order[%0d]: got %0d, expected %0d", k, (k < glog.size()) ? glog[k] : -1, k % NREQ);
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    push_byte(0, 8'hA1, 1'b0);
    push_byte(0, 8'hA2, 1'b0);
    push_byte(0, 8'hA3, 1'b1);
    push_byte(1, 8'hB1, 1'b1);
    drive_reqs();
    wait_acks(1, 20, "lock_first_wait");
    wait_idle(40, "lock_first_idle");
    hold[0] = 1'b1;
    drive_reqs();
    repeat (12) step();
    n_tests++;
    if (glog.size() != 1) begin
      n_fail++;
      $display("FAIL lock_hold: %0d grants while owner idle, expected 1", glog.size());
    end
    hold[0] = 1'b0;
    drive_reqs();
    wait_acks(4, 200, "lock_rest_wait");
    wait_idle(40, "lock_idle");
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (k >= glog.size() || glog[k] != ((k == 3) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL lock_order[%0d]: got %0d, expected %0d", k, (k < glog.size()) ? glog[k] : -1, (k == 3) ? 1 : 0);
      end
    end
    n_tests++;
    if (owner !== 2'd1) begin n_fail++; $display("FAIL lock_owner: got %0d, expected 1", owner); end
  endtask

  task automatic test_timeout();
    int t0;
    int t = 0;
    do_reset();
    uart_mode = UM_STUCK;
    push_byte(2, 8'($urandom), 1'b1);
    drive_reqs();
    wait_acks(1, 10, "to_ack_wait");
    t0 = cyc;
    while (!tx_err && t < 40) begin
      step();
      t++;
    end
    n_tests++;
    if (tx_err !== 1'b1 || cyc - t0 != START_TO + 1) begin
      n_fail++;
      $display("FAIL to_delay: tx_err=%b after %0d cycles from ack, expected 1 after %0d", tx_err, cyc - t0, START_TO + 1);
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy: busy=%b, expected 0", busy); end
    step();
    n_tests++;
    if (tx_err !== 1'b0) begin n_fail++; $display("FAIL to_pulse: tx_err=%b, expected 0", tx_err); end
    uart_mode = UM_AUTO;
    push_byte(3, 8'($urandom), 1'b1);
    push_byte(0, 8'($urandom), 1'b1);
    drive_reqs();
    wait_acks(3, 100, "to_next_wait");
    wait_idle(40, "to_idle");
    n_tests++;
    if (glog.size() < 3 || glog[1] != 3 || glog[2] != 0) begin
      n_fail++;
      $display("FAIL to_recover: grants after timeout %0d,%0d, expected 3,0",
               (glog.size() > 1) ? glog[1] : -1, (glog.size() > 2) ? glog[2] : -1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    uart_mode = UM_MANUAL;
    push_byte(1, 8'h80 | 8'($urandom), 1'b0);
    drive_reqs();
    wait_acks(1, 10, "rm_ack_wait");
    rdy_Tx = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || st_tx !== 1'b0 || req_ack !== '0 || tx_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_ctrl: busy=%b st_tx=%b ack=%b tx_err=%b, expected all 0", busy, st_tx, req_ack, tx_err);
    end
    n_tests++;
    if (DataOUT !== 8'h00 || owner !== '0) begin
      n_fail++;
      $display("FAIL rm_data: DataOUT=%h owner=%0d, expected 00 and 0", DataOUT, owner);
    end
    do_reset();
    push_byte(3, 8'($urandom), 1'b1);
    push_byte(0, 8'($urandom), 1'b1);
    drive_reqs();
    wait_acks(2, 100, "rm_next_wait");
    wait_idle(40, "rm_idle");
    n_tests++;
    if (glog.size() < 1 || glog[0] != 0) begin
      n_fail++;
      $display("FAIL rm_first: first grant %0d, expected 0", (glog.size() > 0) ? glog[0] : -1);
    end
  endtask

  task automatic test_gating();
    int seen = 0;
    do_reset();
    uart_mode = UM_MANUAL;
    rdy_Tx = 1'b0;
    push_byte(1, 8'($urandom), 1'b1);
    drive_reqs();
    repeat (20) begin
      step();
      if (st_tx || req_ack != '0) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL gate_hold: %0d grants while rdy_Tx=0, expected 0", seen); end
    rdy_Tx = 1'b1;
    step();
    n_tests++;
    if (req_ack !== 4'b0010 || st_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL gate_release: ack=%b st_tx=%b, expected 0010 1", req_ack, st_tx);
    end
    rdy_Tx = 1'b0;
    repeat (3) step();
    rdy_Tx = 1'b1;
    wait_idle(10, "gate_idle");
  endtask

  task automatic test_random();
    int total = 0;
    int n;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        push_byte(i, 8'($urandom), (j == n - 1) ? 1'b1 : 1'($urandom_range(0, 1)));
      end
      total += n;
    end
    drive_reqs();
    wait_acks(total, 3000, "rand_wait");
    wait_idle(40, "rand_idle");
    step();
    for (int i = 0; i < NREQ; i++) begin
      n_tests++;
      if (src_head[i] != src_len[i]) begin
        n_fail++;
        $display("FAIL rand_drain[%0d]: %0d bytes consumed, expected %0d", i, src_head[i], src_len[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_timeout();
    test_reset_mid();
    test_gating();
    repeat (3) test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmitter (st_tx / DataOUT / rdy_Tx handshake) among NREQ byte requesters. Supports packet lock: once a requester wins, it keeps the transmitter until it sends a byte flagged last, so multi-byte messages are never interleaved. Sits between the application-side byte sources and the UART top-level TX inputs, and sequences each byte through start, busy-wait and completion. Includes a start timeout so a transmitter that never goes busy cannot deadlock the system.

Parameters:
NREQ, 4, number of requesters (power of two, 2..8)
IDW, 2, width of owner index, equal to log2(NREQ)
START_TO, 15, max cycles to wait for rdy_Tx to fall after the st_tx pulse
TOW, 4, timeout counter width (2^TOW > START_TO)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  NREQ  requester i has a byte pending
req_data  in  8*NREQ  byte of requester i at bits [8i+7:8i]
req_last  in  NREQ  byte of requester i ends its packet
req_ack  out  NREQ  one-cycle pulse: byte of requester i captured
st_tx  out  1  one-cycle start pulse to UART transmitter
DataOUT  out  8  byte presented to UART transmitter, held stable from capture until the byte completes
rdy_Tx  in  1  UART transmitter idle (1) / busy (0)
busy  out  1  arbiter not in IDLE
owner  out  IDW  index of current or last granted requester
tx_err  out  1  one-cycle pulse: start timeout occurred

Behaviour:
- Reset (async, any state): state=IDLE; st_tx=0, req_ack=0, tx_err=0, busy=0, DataOUT=0, owner=0, rr pointer ptr=0, lock=0, timeout count=0.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE: grant only when rdy_Tx=1.
  - lock=0: winner = first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NREQ.
  - lock=1: only owner is eligible. Other requesters wait even when owner's req_valid=0.
  - On grant (registered): DataOUT<=req_data[winner], owner<=winner, store req_last[winner], req_ack[winner]<=1, st_tx<=1, go START.
- START (exactly 1 cycle): st_tx=1, req_ack pulse visible. Next cycle st_tx=0, req_ack=0, count=0, go WAIT_BUSY.
- WAIT_BUSY: if rdy_Tx=0, go WAIT_DONE. Otherwise count++. If count reaches START_TO, pulse tx_err for 1 cycle and go IDLE. The byte counts as consumed (already acked), and the lock/ptr update applies as in WAIT_DONE exit.
- WAIT_DONE: wait for rdy_Tx=1, then go IDLE with the update below. No timeout in this state.
- Update on byte end:
  - stored last=1: lock<=0, ptr<=owner+1 mod NREQ.
  - last=0: lock<=1, ptr unchanged.
- busy=1 in all states except IDLE.
- Minimum byte period: 4 cycles plus the transmitter busy time.
- Requester contract: hold req_valid/req_data/req_last stable until req_ack. Next byte may be presented from the cycle after ack. Dropping req_valid without an ack is allowed; that request is simply withdrawn.
- Simultaneous requests: resolved purely by ptr order within a cycle.
- rdy_Tx toggling while IDLE with no request: ignored.

Decomposition:
- Shared package (uart_pkg): state encoding constants (IDLE=0, START=1, WAIT_BUSY=2, WAIT_DONE=3) and default baud-related constants already used by the TX/RX.
- One sub-module: rr_pick. Combinational priority search with rotation: inputs req mask and ptr; outputs found flag and winner index.
- FSM, lock and timeout logic stay in uart_tx_arbiter.

Test Plan:
- Single request: req_valid=0001, data[7:0]=0x55, last=1. Expected: ack[0] and st_tx in the same cycle, DataOUT=0x55. Model drops rdy_Tx for 100 cycles. Expected: busy returns to 0 one cycle after rdy_Tx rises, ptr=1.
- Fairness: all four requesters valid with last=1 continuously. Expected: grant order 0,1,2,3,0 and each ack exactly once per round.
- Packet lock: req0 sends 3 bytes (last on 3rd) while req1 is valid throughout. Expected: req1 is not acked until req0's 3rd byte completes, then owner=1.
- Start timeout: model keeps rdy_Tx=1 after st_tx. Expected: tx_err pulses exactly START_TO cycles after WAIT_BUSY entry, state returns to IDLE, and the next request is served normally.
- Reset mid-operation: assert rst during WAIT_DONE. Expected: all outputs 0 immediately (async), lock=0, and after release the first request is served from ptr=0.
- Busy transmitter gating: rdy_Tx=0 in IDLE with req_valid=0010. Expected: no st_tx and no ack until rdy_Tx=1, then grant in that cycle.
